// File: rtl/mem_bus_port_if.sv
// Handshake and memory-side signal bundle for mem_bus_port.
// The shared tristate data bus stays a plain inout on the module.
interface mem_bus_port_if;
  logic [31:0] addr;
  logic        start_rd;
  logic        start_wr;
  logic [1:0]  size;
  logic        sext;
  logic        bus_oe;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output addr, start_rd, start_wr, size, sext, bus_oe,
    output mem_ack, mem_rdata,
    input  busy, done, err, mem_req, mem_we,
    input  mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  addr, start_rd, start_wr, size, sext, bus_oe,
    input  mem_ack, mem_rdata,
    output busy, done, err, mem_req, mem_we,
    output mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_bus_port.sv
// Bus consumer port: latches addr/data from the shared buses and runs
// one req/ack memory transaction, returning load data on the data bus.
module mem_bus_port #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_port_if.slave io,
  inout  wire [31:0]    bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic        sext_q, sext_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] wa_q, wa_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;

  logic        go;
  logic        bad;
  logic [1:0]  a_off;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] sh;
  logic [31:0] ext;

  assign a_off = io.addr[1:0];
  assign go    = io.start_rd | io.start_wr;

  // alignment check and lane steering for the incoming request
  always_comb begin
    bad  = 1'b0;
    be_n = 4'b0000;
    wd_n = 32'h0;
    unique case (io.size)
      2'd0: begin
        be_n = 4'b0001 << a_off;
        wd_n = {4{bus[7:0]}};
      end
      2'd1: begin
        bad  = a_off[0];
        be_n = a_off[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{bus[15:0]}};
      end
      2'd2: begin
        bad  = (a_off != 2'b00);
        be_n = 4'b1111;
        wd_n = bus;
      end
      default: bad = 1'b1;
    endcase
  end

  assign sh = io.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = sh;
    unique case (size_q)
      2'd0:    ext = {{24{sext_q & sh[7]}}, sh[7:0]};
      2'd1:    ext = {{16{sext_q & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    we_d    = we_q;
    sext_d  = sext_q;
    size_d  = size_q;
    off_d   = off_q;
    wa_d    = wa_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          size_d = io.size;
          sext_d = io.sext;
          off_d  = a_off;
          wa_d   = io.addr[31:2];
          we_d   = io.start_wr;
          be_d   = be_n;
          wd_d   = io.start_wr ? wd_n : 32'h0;
          cnt_d  = '0;
          err_d  = bad;
          if (bad) done_d = 1'b1;
          else     state_d = REQ;
        end
      end
      REQ: begin
        if (io.mem_ack) begin
          done_d = 1'b1;
          if (we_q) begin
            state_d = IDLE;
          end else begin
            rd_d    = ext;
            state_d = HOLD;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (io.bus_oe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      wa_q    <= '0;
      be_q    <= 4'h0;
      wd_q    <= 32'h0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      size_q  <= size_d;
      off_q   <= off_d;
      wa_q    <= wa_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end

  assign io.busy      = (state_q != IDLE);
  assign io.done      = done_q;
  assign io.err       = err_q;
  assign io.mem_req   = (state_q == REQ);
  assign io.mem_we    = we_q;
  assign io.mem_addr  = {wa_q, 2'b00};
  assign io.mem_be    = be_q;
  assign io.mem_wdata = wd_q;

  assign bus = (state_q == HOLD && io.bus_oe) ? rd_q : 'z;

endmodule

// File: tb/tb_mem_bus_port.sv
// Directed bench for mem_bus_port: vector table of single
// transactions plus timeout, reset-abort and collision sequences.
module tb_mem_bus_port;

  typedef struct packed {
    logic        wr;
    logic        rt;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] d;
    logic [31:0] rdata;
    logic        ebad;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_oe;
  logic [31:0] tb_val;
  wire  [31:0] bus;
  int          total = 0;
  int          bad = 0;

  mem_bus_port_if ifc();

  assign bus = tb_oe ? tb_val : 'z;

  mem_bus_port #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, bit rt, bit [1:0] sz, bit sx,
                              bit [31:0] a, bit [31:0] d,
                              bit [31:0] rd, bit eb, bit [3:0] be,
                              bit [31:0] wd, bit [31:0] res);
    vec_t v;
    v.wr = wr; v.rt = rt; v.size = sz; v.sext = sx;
    v.addr = a; v.d = d; v.rdata = rd; v.ebad = eb;
    v.be = be; v.wd = wd; v.res = res;
    return v;
  endfunction

  task automatic run(input vec_t v, input int dly);
    logic [31:0] ma;
    ma = v.addr & 32'hFFFF_FFFC;
    tb_oe = 1'b1;
    tb_val = v.wr ? v.d : 32'h1234_5678;
    ifc.addr = v.addr;
    ifc.size = v.size;
    ifc.sext = v.sext;
    ifc.start_wr = v.wr;
    ifc.start_rd = !v.wr || v.rt;
    step;
    ifc.start_wr = 1'b0;
    ifc.start_rd = 1'b0;
    ifc.addr = 32'hFFFF_FFFF;
    tb_val = 32'h1234_5678;
    if (v.ebad) begin
      chk("bad_req", ifc.mem_req, 0);
      chk("bad_done", ifc.done, 1);
      chk("bad_err", ifc.err, 1);
      step;
      chk("bad_done_off", ifc.done, 0);
      chk("bad_sticky", ifc.err, 1);
      chk("bad_req2", ifc.mem_req, 0);
      return;
    end
    chk("req", ifc.mem_req, 1);
    chk("busy", ifc.busy, 1);
    chk("we", ifc.mem_we, v.wr);
    chk("maddr", ifc.mem_addr, ma);
    chk("be", ifc.mem_be, v.be);
    chk("wdata", ifc.mem_wdata, v.wd);
    for (int k = 0; k < dly; k++) begin
      step;
      chk("req_hold", ifc.mem_req, 1);
      chk("maddr_hold", ifc.mem_addr, ma);
      chk("done_early", ifc.done, 0);
    end
    ifc.mem_ack = 1'b1;
    ifc.mem_rdata = v.rdata;
    step;
    ifc.mem_ack = 1'b0;
    ifc.mem_rdata = 32'h5A5A_0000;
    chk("done", ifc.done, 1);
    chk("req_drop", ifc.mem_req, 0);
    chk("err_ok", ifc.err, 0);
    if (!v.wr) begin
      chk("hold_busy", ifc.busy, 1);
      chk("bus_undriven", bus, tb_val);
      step;
      chk("hold_stay", ifc.busy, 1);
      chk("hold_done_off", ifc.done, 0);
      tb_oe = 1'b0;
      ifc.bus_oe = 1'b1;
      #1;
      chk("load_res", bus, v.res);
      step;
      ifc.bus_oe = 1'b0;
      tb_oe = 1'b1;
      #1;
      chk("load_idle", ifc.busy, 0);
      chk("bus_release", bus, tb_val);
    end else begin
      chk("st_idle", ifc.busy, 0);
      step;
      chk("st_done_off", ifc.done, 0);
    end
  endtask

  vec_t tbl[14];
  vec_t v1;
  int   n;
  bit   got;

  initial begin
    tbl[0]  = mk(1,0,0,0,'h202,'h0000_00A5,0,0,4'b0100,'hA5A5_A5A5,0);
    tbl[1]  = mk(1,0,1,0,'h306,'h1234_BEEF,0,0,4'b1100,'hBEEF_BEEF,0);
    tbl[2]  = mk(1,0,2,0,'h400,'hCAFE_F00D,0,0,4'b1111,'hCAFE_F00D,0);
    tbl[3]  = mk(0,0,0,1,'h203,0,'h8011_2233,0,4'b1000,0,'hFFFF_FF80);
    tbl[4]  = mk(0,0,0,0,'h203,0,'h8011_2233,0,4'b1000,0,'h0000_0080);
    tbl[5]  = mk(1,0,1,0,'h011,'h0000_5555,0,1,0,0,0);
    tbl[6]  = mk(0,0,1,1,'h502,0,'h9ABC_1234,0,4'b1100,0,'hFFFF_9ABC);
    tbl[7]  = mk(0,0,1,0,'h500,0,'h9ABC_8001,0,4'b0011,0,'h0000_8001);
    tbl[8]  = mk(0,0,2,0,'h702,0,0,1,0,0,0);
    tbl[9]  = mk(0,0,2,0,'h604,0,'h1357_9BDF,0,4'b1111,0,'h1357_9BDF);
    tbl[10] = mk(1,0,3,0,'h000,'h0000_0001,0,1,0,0,0);
    tbl[11] = mk(0,0,0,1,'h601,0,'h0000_7F00,0,4'b0010,0,'h0000_007F);
    tbl[12] = mk(1,1,1,0,'h008,'h0000_ABCD,0,0,4'b0011,'hABCD_ABCD,0);
    tbl[13] = mk(1,0,0,0,'h003,'h1234_5677,0,0,4'b1000,'h7777_7777,0);
    v1 = mk(1,0,2,0,'h100,'hDEAD_BEEF,0,0,4'b1111,'hDEAD_BEEF,0);

    rst = 1'b1;
    tb_oe = 1'b1;
    tb_val = 32'h1234_5678;
    ifc.addr = 32'h0;
    ifc.start_rd = 1'b0;
    ifc.start_wr = 1'b0;
    ifc.size = 2'd0;
    ifc.sext = 1'b0;
    ifc.bus_oe = 1'b0;
    ifc.mem_ack = 1'b0;
    ifc.mem_rdata = 32'h0;
    #1;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_req", ifc.mem_req, 0);
    chk("rst_we", ifc.mem_we, 0);
    chk("rst_maddr", ifc.mem_addr, 0);
    chk("rst_be", ifc.mem_be, 0);
    chk("rst_wdata", ifc.mem_wdata, 0);
    chk("rst_bus", bus, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step;

    run(v1, 2);

    for (int i = 0; i < 14; i++) run(tbl[i], i % 3);

    tb_val = 32'h1234_5678;
    ifc.addr = 32'h800;
    ifc.size = 2'd2;
    ifc.start_rd = 1'b1;
    step;
    ifc.start_rd = 1'b0;
    chk("tmo_req", ifc.mem_req, 1);
    n = 1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step;
      if (ifc.mem_req) n++;
      else got = 1'b1;
    end
    chk("tmo_len", n, 16);
    chk("tmo_done", ifc.done, 1);
    chk("tmo_err", ifc.err, 1);
    chk("tmo_busy", ifc.busy, 0);
    chk("tmo_bus", bus, 32'h1234_5678);
    ifc.mem_ack = 1'b1;
    ifc.mem_rdata = 32'hFFFF_FFFF;
    step;
    ifc.mem_ack = 1'b0;
    chk("stray_ack_done", ifc.done, 0);
    chk("tmo_err_sticky", ifc.err, 1);
    chk("stray_ack_idle", ifc.busy, 0);

    tb_val = 32'h1111_2222;
    ifc.addr = 32'h900;
    ifc.size = 2'd2;
    ifc.start_wr = 1'b1;
    step;
    ifc.start_wr = 1'b0;
    chk("mid_req", ifc.mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", ifc.mem_req, 0);
    chk("arst_busy", ifc.busy, 0);
    chk("arst_we", ifc.mem_we, 0);
    chk("arst_maddr", ifc.mem_addr, 0);
    chk("arst_be", ifc.mem_be, 0);
    chk("arst_wdata", ifc.mem_wdata, 0);
    chk("arst_err", ifc.err, 0);
    @(negedge clk);
    rst = 1'b0;
    step;
    chk("post_rst_idle", ifc.busy, 0);
    run(v1, 1);
    run(tbl[3], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
